// File: rtl/data_mem_unit.sv
// Y86-64 data memory stage: IDLE -> ACCESS -> RESP handshake, LATENCY edges per memory op, 1 edge per no-op.
// Optional macro DMEM_ALIGN_CHECK_EN makes a misaligned address (addr[2:0] != 0) take the error path.
module data_mem_unit #(
   parameter int DATA_W  = 64,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        icode,
   input  logic [DATA_W-1:0] valA,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valP,
   output logic              resp_valid,
   output logic [DATA_W-1:0] valM,
   output logic              dmem_error,
   output logic [DATA_W-1:0] datamem
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [2:0] LAST     = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

   logic [1:0]        state;
   logic [2:0]        cnt;
   logic [3:0]        cap_icode;
   logic [DATA_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [3:0]        cur_icode;
   logic [DATA_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [DATA_W-1:0] word_idx;
   logic              accept, wr, rd, mem_op, bad, enter_resp, do_write;

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP);
   assign accept     = req_ready && req_valid;

   // In IDLE the live inputs are decoded so LATENCY=1 and no-ops can resolve on the accepting edge.
   always_comb begin
      cur_icode = cap_icode;
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
      if (state == S_IDLE) begin
         cur_icode = icode;
         cur_addr  = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
         cur_wdata = (icode == 4'h8) ? valP : valA;
      end
   end

   assign wr       = (cur_icode == 4'h4) || (cur_icode == 4'h8) || (cur_icode == 4'hA);
   assign rd       = (cur_icode == 4'h5) || (cur_icode == 4'h9) || (cur_icode == 4'hB);
   assign mem_op   = wr || rd;
   assign word_idx = cur_addr >> 3;

`ifdef DMEM_ALIGN_CHECK_EN
   assign bad = (word_idx >= DATA_W'(DEPTH)) || (cur_addr[2:0] != 3'd0);
`else
   assign bad = (word_idx >= DATA_W'(DEPTH));
`endif

   assign enter_resp = (accept && (!mem_op || LATENCY == 1)) ||
                       (state == S_ACCESS && cnt == LAST);
   assign do_write   = enter_resp && wr && !bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         cap_icode  <= 4'h0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         valM       <= '0;
         dmem_error <= 1'b0;
         datamem    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cap_icode <= cur_icode;
                  cap_addr  <= cur_addr;
                  cap_wdata <= cur_wdata;
                  cnt       <= 3'd0;
                  state     <= enter_resp ? S_RESP : S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (cnt == LAST) state <= S_RESP;
               else             cnt   <= cnt + 3'd1;
            end
            default: state <= S_IDLE;
         endcase

         if (enter_resp) begin
            valM       <= (rd && !bad) ? mem[word_idx[AW-1:0]] : '0;
            dmem_error <= mem_op && bad;
         end
         if (do_write) datamem <= cur_wdata;
      end
   end

   // Array has no reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (do_write) mem[word_idx[AW-1:0]] <= cur_wdata;
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit against a word-array model of the Y86-64 memory stage.
module tb_data_mem_unit;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  icode = 4'h0;
   logic [63:0] valA = '0, valE = '0, valP = '0;
   logic        resp_valid;
   logic [63:0] valM;
   logic        dmem_error;
   logic [63:0] datamem;

   int checks = 0;
   int errors = 0;

   logic [63:0] model_mem [1024];
   logic [63:0] model_dm = '0;

   data_mem_unit #(.DATA_W(64), .DEPTH(1024), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .icode(icode), .valA(valA), .valE(valE), .valP(valP),
      .resp_valid(resp_valid), .valM(valM), .dmem_error(dmem_error), .datamem(datamem)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One complete transaction: drive, accept, watch busy window, check response against the model.
   task automatic run(input string tag, input logic [3:0] ic, input logic [63:0] a,
                      input logic [63:0] e, input logic [63:0] p);
      logic [63:0] addr, wdata, exp_m;
      logic        isw, isr, bad, exp_err;
      int          exp_lat, lat;
      int          idx;
      isw   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
      isr   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
      addr  = (ic == 4'h9 || ic == 4'hB) ? a : e;
      wdata = (ic == 4'h8) ? p : a;
      bad   = (addr / 8) >= 1024;
`ifdef DMEM_ALIGN_CHECK_EN
      if (addr % 8 != 0) bad = 1'b1;
`endif
      idx     = bad ? 0 : int'(addr / 8);
      exp_lat = (isw || isr) ? LAT : 1;
      exp_err = (isw || isr) && bad;
      exp_m   = (isr && !bad) ? model_mem[idx] : 64'h0;

      @(negedge clk);
      check({tag, ".ready"}, {63'h0, req_ready}, 64'h1);
      req_valid = 1'b1; icode = ic; valA = a; valE = e; valP = p;
      @(posedge clk);
      #1;
      // Scramble inputs while busy; req_valid stays high to prove it is ignored.
      icode = 4'(ic ^ 4'hF); valA = {$urandom, $urandom}; valE = {$urandom, $urandom}; valP = ~p;
      lat = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         check({tag, ".busy"}, {63'h0, req_ready}, 64'h0);
         if (resp_valid || lat >= 20) break;
      end
      req_valid = 1'b0;
      if (isw && !bad) begin
         model_mem[idx] = wdata;
         model_dm       = wdata;
      end
      check({tag, ".lat"},  64'(lat), 64'(exp_lat));
      check({tag, ".valM"}, valM, exp_m);
      check({tag, ".err"},  {63'h0, dmem_error}, {63'h0, exp_err});
      check({tag, ".dm"},   datamem, model_dm);
      @(negedge clk);
      check({tag, ".pulse"}, {63'h0, resp_valid}, 64'h0);
      check({tag, ".hold"},  valM, exp_m);
   endtask

   initial begin
      logic [3:0]  ops [8];
      logic [63:0] ad;
      int          k;
      ops[0] = 4'h4; ops[1] = 4'h5; ops[2] = 4'h8; ops[3] = 4'h9;
      ops[4] = 4'hA; ops[5] = 4'hB; ops[6] = 4'h6; ops[7] = 4'h0;

      #12;
      check("rst.ready", {63'h0, req_ready}, 64'h1);
      check("rst.resp",  {63'h0, resp_valid}, 64'h0);
      check("rst.valM",  valM, 64'h0);
      check("rst.err",   {63'h0, dmem_error}, 64'h0);
      check("rst.dm",    datamem, 64'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 128; i++) run("pre", 4'h4, {$urandom, $urandom}, 64'(i * 8), 64'h0);

      run("push", 4'hA, 64'h55, 64'h20, 64'h0);
      check("push.dm55", datamem, 64'h55);
      run("pop", 4'hB, 64'h20, 64'h0, 64'h0);
      run("call", 4'h8, 64'h0, 64'h100, 64'h4A);
      run("ret", 4'h9, 64'h100, 64'h0, 64'h0);
      run("oob.rd", 4'h5, 64'h0, 64'h2000, 64'h0);
      run("oob.wr", 4'h4, 64'hDEAD, 64'h2000, 64'h0);
      run("top.wr", 4'h4, 64'hBEEF, 64'h1FF8, 64'h0);
      run("top.rd", 4'h5, 64'h0, 64'h1FF8, 64'h0);
      run("mis.wr", 4'h4, 64'h1234, 64'h13, 64'h0);
      run("mis.rd", 4'h5, 64'h0, 64'h10, 64'h0);
      run("noop", 4'h6, 64'h99, 64'h18, 64'h0);
      run("noop.rd", 4'h5, 64'h0, 64'h18, 64'h0);

      // Reset in the middle of an rmmovq: the write must never land.
      @(negedge clk);
      req_valid = 1'b1; icode = 4'h4; valA = 64'h77; valE = 64'h40;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst.ready", {63'h0, req_ready}, 64'h1);
      check("arst.resp",  {63'h0, resp_valid}, 64'h0);
      check("arst.dm",    datamem, 64'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      model_dm = 64'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst.noresp", {63'h0, resp_valid}, 64'h0);
      end
      run("arst.rd", 4'h5, 64'h0, 64'h40, 64'h0);

      for (int i = 0; i < 250; i++) begin
         k  = int'($urandom_range(0, 7));
         ad = ($urandom_range(0, 9) == 0) ? 64'(32'h2000 + $urandom_range(0, 4095))
                                          : 64'($urandom_range(0, 1023));
         run("rnd", ops[k], ad, ad, {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
